// File: rtl/mmu_pkg.sv
// Shared MMU types: stored TLB entry, address segment, per-port translation result,
// plus the entry match rule used by both probe and lookup.
package mmu_pkg;

    localparam int         MAX_ASID_BITS     = 16;
    localparam logic [2:0] CACHE_ATTR_CACHED = 3'd3;

    typedef enum logic [2:0] {USEG, KSEG0, KSEG1, KSSEG, KSEG3} seg_t;

    typedef struct packed {
        logic [11:0]              mask;
        logic [18:0]              vpn2;
        logic [MAX_ASID_BITS-1:0] asid;
        logic                     g;
        logic [19:0]              pfn0;
        logic [2:0]               c0;
        logic                     d0;
        logic                     v0;
        logic [19:0]              pfn1;
        logic [2:0]               c1;
        logic                     d1;
        logic                     v1;
    } tlb_entry_t;

    typedef struct packed {
        logic [31:0] pa;
        logic        hit;
        logic        valid;
        logic        dirty;
        logic        cached;
        logic        err;
    } tlb_result_t;

    function automatic tlb_entry_t entry_reset();
        tlb_entry_t e;
        e    = '0;
        e.c0 = CACHE_ATTR_CACHED;
        e.c1 = CACHE_ATTR_CACHED;
        return e;
    endfunction

    // VPN2 is stored pre-masked, so only the incoming VPN2 needs masking here.
    function automatic logic entry_match(tlb_entry_t e, logic [18:0] vpn2,
                                         logic [MAX_ASID_BITS-1:0] asid);
        return ((vpn2 & ~{7'b0, e.mask}) == e.vpn2) && (e.g || (e.asid == asid));
    endfunction

    function automatic seg_t seg_of(logic [31:0] va);
        if (!va[31]) return USEG;
        case (va[30:29])
            2'b00:   return KSEG0;
            2'b01:   return KSEG1;
            2'b10:   return KSSEG;
            default: return KSEG3;
        endcase
    endfunction

endpackage

// File: rtl/tlb_multiport_if.sv
// Lookup-port bundle between the fetch/LSU address stages (master) and the TLB (slave).
interface tlb_multiport_if #(
    parameter int NUM_PORTS = 2
) ();
    logic [NUM_PORTS-1:0]        lk_req_i;
    logic [NUM_PORTS-1:0]        lk_hold_i;
    logic [NUM_PORTS-1:0][31:0]  lk_va_i;
    logic [NUM_PORTS-1:0]        lk_vld_o;
    logic [NUM_PORTS-1:0][31:0]  lk_pa_o;
    logic [NUM_PORTS-1:0]        lk_hit_o;
    logic [NUM_PORTS-1:0]        lk_valid_o;
    logic [NUM_PORTS-1:0]        lk_dirty_o;
    logic [NUM_PORTS-1:0]        lk_cached_o;
    logic [NUM_PORTS-1:0]        lk_err_o;

    modport master (
        output lk_req_i, lk_hold_i, lk_va_i,
        input  lk_vld_o, lk_pa_o, lk_hit_o, lk_valid_o, lk_dirty_o, lk_cached_o, lk_err_o
    );

    modport slave (
        input  lk_req_i, lk_hold_i, lk_va_i,
        output lk_vld_o, lk_pa_o, lk_hit_o, lk_valid_o, lk_dirty_o, lk_cached_o, lk_err_o
    );
endinterface

// File: rtl/tlb_lookup_port.sv
// One translation port: segment decode, entry search over the shared array,
// and a holdable one-cycle result register.
module tlb_lookup_port
    import mmu_pkg::*;
#(
    parameter int TLB_NUM   = 32,
    parameter int ASID_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  tlb_entry_t           i_entries [TLB_NUM],
    input  logic                 i_req,
    input  logic                 i_hold,
    input  logic [31:0]          i_va,
    input  logic [ASID_BITS-1:0] i_asid,
    input  logic                 i_kernel,
    input  logic                 i_erl,
    input  logic                 i_kseg0_cached,
    output logic                 o_vld,
    output tlb_result_t          o_res
);

    tlb_entry_t  w_ent;
    logic        w_hit;
    logic        w_odd;
    logic [19:0] w_pfn;
    logic [2:0]  w_c;
    logic        w_d;
    logic        w_v;
    tlb_result_t w_res;
    logic        r_vld_p1;
    tlb_result_t r_res_p1;

    always_comb begin
        w_hit = 1'b0;
        w_ent = i_entries[0];
        // Descending scan leaves the lowest matching index selected on a multi-hit.
        for (int i = TLB_NUM - 1; i >= 0; i--) begin
            if (entry_match(i_entries[i], i_va[31:13], MAX_ASID_BITS'(i_asid))) begin
                w_hit = 1'b1;
                w_ent = i_entries[i];
            end
        end
        w_odd = |(i_va & ({8'b0, w_ent.mask, 12'hfff} + 32'd1));
        w_pfn = w_odd ? w_ent.pfn1 : w_ent.pfn0;
        w_c   = w_odd ? w_ent.c1   : w_ent.c0;
        w_d   = w_odd ? w_ent.d1   : w_ent.d0;
        w_v   = w_odd ? w_ent.v1   : w_ent.v0;

        w_res = '0;
        case (seg_of(i_va))
            USEG: begin
                if (i_kernel && i_erl) begin
                    w_res.pa    = {3'b0, i_va[28:0]};
                    w_res.hit   = 1'b1;
                    w_res.valid = 1'b1;
                    w_res.dirty = 1'b1;
                end else if (w_hit) begin
                    w_res.pa     = {w_pfn & ~{8'b0, w_ent.mask}, 12'h000}
                                 | (i_va & {8'b0, w_ent.mask, 12'hfff});
                    w_res.hit    = 1'b1;
                    w_res.valid  = w_v;
                    w_res.dirty  = w_d;
                    w_res.cached = (w_c == CACHE_ATTR_CACHED);
                end
            end
            KSEG0, KSEG1: begin
                if (i_kernel) begin
                    w_res.pa     = {3'b0, i_va[28:0]};
                    w_res.hit    = 1'b1;
                    w_res.valid  = 1'b1;
                    w_res.dirty  = 1'b1;
                    w_res.cached = (seg_of(i_va) == KSEG0) && i_kseg0_cached;
                end else begin
                    w_res.err = 1'b1;
                end
            end
            KSEG3: begin
                if (!i_kernel) begin
                    w_res.err = 1'b1;
                end else if (w_hit) begin
                    w_res.pa     = {w_pfn & ~{8'b0, w_ent.mask}, 12'h000}
                                 | (i_va & {8'b0, w_ent.mask, 12'hfff});
                    w_res.hit    = 1'b1;
                    w_res.valid  = w_v;
                    w_res.dirty  = w_d;
                    w_res.cached = (w_c == CACHE_ATTR_CACHED);
                end
            end
            default: w_res.err = 1'b1;
        endcase
    end

    // Stage p0 -> p1: result register, frozen entirely while held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
            r_res_p1 <= '0;
        end else if (!i_hold) begin
            r_vld_p1 <= i_req;
            if (i_req) r_res_p1 <= w_res;
        end
    end

    assign o_vld = r_vld_p1;
    assign o_res = r_res_p1;

endmodule

// File: rtl/tlb_multiport.sv
// Joint TLB: shared entry array with TLBWI/TLBWR/TLBR, Random/Wired, registered
// TLBP with multi-hit flag, and NUM_PORTS registered translation ports.
module tlb_multiport
    import mmu_pkg::*;
#(
    parameter int  TLB_NUM   = 32,
    parameter int  NUM_PORTS = 2,
    parameter int  ASID_BITS = 8,
    localparam int IDX_BITS  = $clog2(TLB_NUM)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tlbwi_i,
    input  logic                tlbwr_i,
    input  logic                tlbp_i,
    input  logic [IDX_BITS-1:0] index_i,
    input  logic [11:0]         mask_i,
    input  logic [31:0]         entryhi_i,
    input  logic [31:0]         entrylo0_i,
    input  logic [31:0]         entrylo1_i,
    input  logic                wired_we_i,
    input  logic [IDX_BITS-1:0] wired_i,
    output logic [11:0]         mask_o,
    output logic [31:0]         entryhi_o,
    output logic [31:0]         entrylo0_o,
    output logic [31:0]         entrylo1_o,
    output logic [IDX_BITS-1:0] random_o,
    output logic                probe_done_o,
    output logic [31:0]         probe_index_o,
    output logic                probe_multi_o,
    input  logic                kernel_mode_i,
    input  logic                erl_i,
    input  logic                kseg0_cached_i,
    tlb_multiport_if.slave      lk
);

    localparam logic [IDX_BITS-1:0] RAND_TOP = IDX_BITS'(TLB_NUM - 1);

    tlb_entry_t                 r_entries [TLB_NUM];
    logic [IDX_BITS-1:0]        r_random;
    logic [IDX_BITS-1:0]        r_wired;
    logic                       r_probe_done_p1;
    logic [31:0]                r_probe_idx_p1;
    logic                       r_probe_multi_p1;
    logic                       w_we;
    logic [IDX_BITS-1:0]        w_widx;
    tlb_entry_t                 w_new;
    tlb_entry_t                 w_rd;
    logic [MAX_ASID_BITS-1:0]   w_cur_asid;
    logic                       w_phit;
    logic                       w_pmulti;
    logic [IDX_BITS-1:0]        w_pidx;
    logic                       w_unused;

    assign w_unused   = ^{entrylo0_i[31:26], entrylo1_i[31:26], entryhi_i[12:ASID_BITS]};
    assign w_cur_asid = MAX_ASID_BITS'(entryhi_i[ASID_BITS-1:0]);
    assign w_we       = tlbwi_i | tlbwr_i;
    assign w_widx     = tlbwi_i ? index_i : r_random;

    always_comb begin
        w_new      = '0;
        w_new.mask = mask_i;
        w_new.vpn2 = entryhi_i[31:13] & ~{7'b0, mask_i};
        w_new.asid = w_cur_asid;
        w_new.g    = entrylo0_i[0] & entrylo1_i[0];
        w_new.pfn0 = entrylo0_i[25:6] & ~{8'b0, mask_i};
        w_new.c0   = entrylo0_i[5:3];
        w_new.d0   = entrylo0_i[2];
        w_new.v0   = entrylo0_i[1];
        w_new.pfn1 = entrylo1_i[25:6] & ~{8'b0, mask_i};
        w_new.c1   = entrylo1_i[5:3];
        w_new.d1   = entrylo1_i[2];
        w_new.v1   = entrylo1_i[1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TLB_NUM; i++) r_entries[i] <= entry_reset();
        end else if (w_we && (int'(w_widx) < TLB_NUM)) begin
            r_entries[w_widx] <= w_new;
        end
    end

    // Wired at or above the top index leaves no replaceable slots, so Random parks at the top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_random <= RAND_TOP;
            r_wired  <= '0;
        end else begin
            if (wired_we_i) r_wired <= wired_i;
            if (wired_we_i || (int'(r_wired) >= TLB_NUM - 1) ||
                (r_random == r_wired) || (r_random == '0))
                r_random <= RAND_TOP;
            else
                r_random <= r_random - IDX_BITS'(1);
        end
    end

    assign w_rd       = (int'(index_i) < TLB_NUM) ? r_entries[index_i] : '0;
    assign mask_o     = w_rd.mask;
    assign entryhi_o  = {w_rd.vpn2, 13'(w_rd.asid)};
    assign entrylo0_o = {6'b0, w_rd.pfn0, w_rd.c0, w_rd.d0, w_rd.v0, w_rd.g};
    assign entrylo1_o = {6'b0, w_rd.pfn1, w_rd.c1, w_rd.d1, w_rd.v1, w_rd.g};
    assign random_o   = r_random;

    always_comb begin
        w_phit   = 1'b0;
        w_pmulti = 1'b0;
        w_pidx   = '0;
        for (int i = 0; i < TLB_NUM; i++) begin
            if (entry_match(r_entries[i], entryhi_i[31:13], w_cur_asid)) begin
                w_pmulti = w_pmulti | w_phit;
                w_phit   = 1'b1;
                w_pidx   = w_pidx | IDX_BITS'(i);
            end
        end
    end

    // Stage p0 -> p1: probe result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_probe_done_p1  <= 1'b0;
            r_probe_idx_p1   <= '0;
            r_probe_multi_p1 <= 1'b0;
        end else begin
            r_probe_done_p1 <= tlbp_i;
            if (tlbp_i) begin
                r_probe_idx_p1   <= w_phit ? 32'(w_pidx) : 32'h8000_0000;
                r_probe_multi_p1 <= w_pmulti;
            end
        end
    end

    assign probe_done_o  = r_probe_done_p1;
    assign probe_index_o = r_probe_idx_p1;
    assign probe_multi_o = r_probe_multi_p1;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        tlb_result_t w_res;

        tlb_lookup_port #(
            .TLB_NUM   (TLB_NUM),
            .ASID_BITS (ASID_BITS)
        ) u_port (
            .clk            (clk),
            .rst            (rst),
            .i_entries      (r_entries),
            .i_req          (lk.lk_req_i[p]),
            .i_hold         (lk.lk_hold_i[p]),
            .i_va           (lk.lk_va_i[p]),
            .i_asid         (entryhi_i[ASID_BITS-1:0]),
            .i_kernel       (kernel_mode_i),
            .i_erl          (erl_i),
            .i_kseg0_cached (kseg0_cached_i),
            .o_vld          (lk.lk_vld_o[p]),
            .o_res          (w_res)
        );

        assign lk.lk_pa_o[p]     = w_res.pa;
        assign lk.lk_hit_o[p]    = w_res.hit;
        assign lk.lk_valid_o[p]  = w_res.valid;
        assign lk.lk_dirty_o[p]  = w_res.dirty;
        assign lk.lk_cached_o[p] = w_res.cached;
        assign lk.lk_err_o[p]    = w_res.err;
    end

endmodule

// File: tb/tb_tlb_multiport.sv
// Directed bench for tlb_multiport (8 entries, 2 ports): reset, writes, probes,
// mapped/unmapped lookups, page-mask select, Random/Wired, hold and async reset.
module tb_tlb_multiport;

    localparam int TLB_NUM   = 8;
    localparam int NUM_PORTS = 2;
    localparam int ASID_BITS = 8;
    localparam int IDX_BITS  = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                tlbwi_i, tlbwr_i, tlbp_i;
    logic [IDX_BITS-1:0] index_i;
    logic [11:0]         mask_i;
    logic [31:0]         entryhi_i, entrylo0_i, entrylo1_i;
    logic                wired_we_i;
    logic [IDX_BITS-1:0] wired_i;
    logic [11:0]         mask_o;
    logic [31:0]         entryhi_o, entrylo0_o, entrylo1_o;
    logic [IDX_BITS-1:0] random_o;
    logic                probe_done_o;
    logic [31:0]         probe_index_o;
    logic                probe_multi_o;
    logic                kernel_mode_i, erl_i, kseg0_cached_i;

    int n_checks = 0;
    int n_errors = 0;
    logic [2:0] exp_seq [5];

    tlb_multiport_if #(.NUM_PORTS(NUM_PORTS)) lk_bus ();

    tlb_multiport #(
        .TLB_NUM   (TLB_NUM),
        .NUM_PORTS (NUM_PORTS),
        .ASID_BITS (ASID_BITS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .tlbwi_i        (tlbwi_i),
        .tlbwr_i        (tlbwr_i),
        .tlbp_i         (tlbp_i),
        .index_i        (index_i),
        .mask_i         (mask_i),
        .entryhi_i      (entryhi_i),
        .entrylo0_i     (entrylo0_i),
        .entrylo1_i     (entrylo1_i),
        .wired_we_i     (wired_we_i),
        .wired_i        (wired_i),
        .mask_o         (mask_o),
        .entryhi_o      (entryhi_o),
        .entrylo0_o     (entrylo0_o),
        .entrylo1_o     (entrylo1_o),
        .random_o       (random_o),
        .probe_done_o   (probe_done_o),
        .probe_index_o  (probe_index_o),
        .probe_multi_o  (probe_multi_o),
        .kernel_mode_i  (kernel_mode_i),
        .erl_i          (erl_i),
        .kseg0_cached_i (kseg0_cached_i),
        .lk             (lk_bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] idx, input logic [11:0] m, input logic [31:0] hi,
                      input logic [31:0] lo0, input logic [31:0] lo1);
        index_i    = idx;
        mask_i     = m;
        entryhi_i  = hi;
        entrylo0_i = lo0;
        entrylo1_i = lo1;
        tlbwi_i    = 1'b1;
        tick();
        tlbwi_i    = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tlbwi_i = 1'b0; tlbwr_i = 1'b0; tlbp_i = 1'b0;
        index_i = '0; mask_i = '0; entryhi_i = '0; entrylo0_i = '0; entrylo1_i = '0;
        wired_we_i = 1'b0; wired_i = '0;
        kernel_mode_i = 1'b0; erl_i = 1'b0; kseg0_cached_i = 1'b0;
        lk_bus.lk_req_i = '0; lk_bus.lk_hold_i = '0; lk_bus.lk_va_i = '0;
        exp_seq = '{3'd6, 3'd5, 3'd4, 3'd7, 3'd6};

        tick(); tick();
        check_eq("rst_random",     32'(random_o), 32'd7);
        check_eq("rst_lk_vld",     32'(lk_bus.lk_vld_o), 32'd0);
        check_eq("rst_probe_done", 32'(probe_done_o), 32'd0);
        check_eq("rst_entrylo0",   entrylo0_o, 32'h0000_0018);
        rst = 1'b0;

        // empty TLB, user lookup
        lk_bus.lk_req_i[0] = 1'b1; lk_bus.lk_va_i[0] = 32'h0040_0000;
        tick();
        lk_bus.lk_req_i = '0;
        check_eq("empty_vld",  32'(lk_bus.lk_vld_o), 32'd1);
        check_eq("empty_hit",  32'(lk_bus.lk_hit_o[0]), 32'd0);
        check_eq("empty_err",  32'(lk_bus.lk_err_o[0]), 32'd0);
        tick();
        check_eq("vld_drop",   32'(lk_bus.lk_vld_o), 32'd0);

        // write idx 5 with probe + lookup in the same cycle: both see old contents
        entryhi_i = 32'h0040_0001; mask_i = '0; entrylo0_i = 32'h0000_401E; entrylo1_i = 32'h0000_801C;
        index_i = 3'd5; tlbwi_i = 1'b1; tlbp_i = 1'b1;
        lk_bus.lk_req_i[1] = 1'b1; lk_bus.lk_va_i[1] = 32'h0040_0123;
        tick();
        tlbwi_i = 1'b0; tlbp_i = 1'b0;
        check_eq("probe_empty_done", 32'(probe_done_o), 32'd1);
        check_eq("probe_empty_idx",  probe_index_o, 32'h8000_0000);
        check_eq("probe_empty_mult", 32'(probe_multi_o), 32'd0);
        check_eq("prewrite_hit",     32'(lk_bus.lk_hit_o[1]), 32'd0);

        lk_bus.lk_req_i = 2'b11;
        lk_bus.lk_va_i[0] = 32'h0040_0123; lk_bus.lk_va_i[1] = 32'h0040_1004;
        tick();
        check_eq("even_pa",     lk_bus.lk_pa_o[0], 32'h0010_0123);
        check_eq("even_hit",    32'(lk_bus.lk_hit_o[0]), 32'd1);
        check_eq("even_valid",  32'(lk_bus.lk_valid_o[0]), 32'd1);
        check_eq("even_dirty",  32'(lk_bus.lk_dirty_o[0]), 32'd1);
        check_eq("even_cached", 32'(lk_bus.lk_cached_o[0]), 32'd1);
        check_eq("odd_pa",      lk_bus.lk_pa_o[1], 32'h0020_0004);
        check_eq("odd_hit",     32'(lk_bus.lk_hit_o[1]), 32'd1);
        check_eq("odd_valid",   32'(lk_bus.lk_valid_o[1]), 32'd0);
        check_eq("probe_pulse", 32'(probe_done_o), 32'd0);
        check_eq("tlbr_hi",     entryhi_o, 32'h0040_0001);
        check_eq("tlbr_lo0",    entrylo0_o, 32'h0000_401E);
        check_eq("tlbr_lo1",    entrylo1_o, 32'h0000_801C);

        // ASID mismatch
        entryhi_i = 32'h0040_0002;
        lk_bus.lk_req_i = 2'b01; lk_bus.lk_va_i[0] = 32'h0040_0123;
        tick();
        check_eq("asid_miss_hit", 32'(lk_bus.lk_hit_o[0]), 32'd0);
        check_eq("asid_miss_pa",  lk_bus.lk_pa_o[0], 32'h0);

        // probe single hit
        entryhi_i = 32'h0040_0001; lk_bus.lk_req_i = '0; tlbp_i = 1'b1;
        tick();
        tlbp_i = 1'b0;
        check_eq("probe_idx",   probe_index_o, 32'd5);
        check_eq("probe_multi", 32'(probe_multi_o), 32'd0);

        // duplicate at idx 2 -> multi-hit, index = 5|2
        wr(3'd2, 12'h000, 32'h0040_0001, 32'h0000_401E, 32'h0000_801C);
        tlbp_i = 1'b1;
        tick();
        tlbp_i = 1'b0;
        check_eq("multi_flag", 32'(probe_multi_o), 32'd1);
        check_eq("multi_idx",  probe_index_o, 32'd7);

        // 16K pages at idx 2: select on va[14], PFN stored masked
        wr(3'd2, 12'h003, 32'h0040_0001, 32'h0000_405E, 32'h0000_8012);
        lk_bus.lk_req_i = 2'b11;
        lk_bus.lk_va_i[0] = 32'h0040_2004; lk_bus.lk_va_i[1] = 32'h0040_4008;
        tick();
        check_eq("m16_even_pa",     lk_bus.lk_pa_o[0], 32'h0010_2004);
        check_eq("m16_even_cached", 32'(lk_bus.lk_cached_o[0]), 32'd1);
        check_eq("m16_odd_pa",      lk_bus.lk_pa_o[1], 32'h0020_0008);
        check_eq("m16_odd_valid",   32'(lk_bus.lk_valid_o[1]), 32'd1);
        check_eq("m16_odd_dirty",   32'(lk_bus.lk_dirty_o[1]), 32'd0);
        check_eq("m16_odd_cached",  32'(lk_bus.lk_cached_o[1]), 32'd0);
        check_eq("m16_mask_o",      32'(mask_o), 32'h3);
        check_eq("m16_lo0_masked",  entrylo0_o, 32'h0000_401E);

        // segments, user mode
        lk_bus.lk_va_i[0] = 32'h8000_0000; lk_bus.lk_va_i[1] = 32'hE000_0000;
        tick();
        check_eq("user_kseg0_err", 32'(lk_bus.lk_err_o[0]), 32'd1);
        check_eq("user_kseg0_hit", 32'(lk_bus.lk_hit_o[0]), 32'd0);
        check_eq("user_kseg0_pa",  lk_bus.lk_pa_o[0], 32'h0);
        check_eq("user_kseg3_err", 32'(lk_bus.lk_err_o[1]), 32'd1);

        // segments, kernel mode
        kernel_mode_i = 1'b1; kseg0_cached_i = 1'b1;
        lk_bus.lk_va_i[0] = 32'hA000_1000; lk_bus.lk_va_i[1] = 32'h8000_2000;
        tick();
        check_eq("kseg1_pa",     lk_bus.lk_pa_o[0], 32'h0000_1000);
        check_eq("kseg1_hit",    32'(lk_bus.lk_hit_o[0]), 32'd1);
        check_eq("kseg1_cached", 32'(lk_bus.lk_cached_o[0]), 32'd0);
        check_eq("kseg0_pa",     lk_bus.lk_pa_o[1], 32'h0000_2000);
        check_eq("kseg0_cached", 32'(lk_bus.lk_cached_o[1]), 32'd1);

        erl_i = 1'b1;
        lk_bus.lk_va_i[0] = 32'h0040_0123; lk_bus.lk_va_i[1] = 32'hC000_0000;
        tick();
        erl_i = 1'b0;
        check_eq("erl_useg_pa",     lk_bus.lk_pa_o[0], 32'h0040_0123);
        check_eq("erl_useg_cached", 32'(lk_bus.lk_cached_o[0]), 32'd0);
        check_eq("ksseg_err",       32'(lk_bus.lk_err_o[1]), 32'd1);

        // hold on port 0
        lk_bus.lk_req_i = 2'b01; lk_bus.lk_va_i[0] = 32'hA000_1000;
        tick();
        check_eq("hold_pre_pa", lk_bus.lk_pa_o[0], 32'h0000_1000);
        lk_bus.lk_hold_i = 2'b01; lk_bus.lk_va_i[0] = 32'hA000_3000;
        tick();
        check_eq("hold_pa",  lk_bus.lk_pa_o[0], 32'h0000_1000);
        lk_bus.lk_req_i = '0;
        tick();
        check_eq("hold_vld", 32'(lk_bus.lk_vld_o[0]), 32'd1);
        lk_bus.lk_hold_i = '0;
        tick();
        check_eq("unhold_vld", 32'(lk_bus.lk_vld_o[0]), 32'd0);
        kernel_mode_i = 1'b0;

        // Random with wired=4
        wired_we_i = 1'b1; wired_i = 3'd4;
        tick();
        wired_we_i = 1'b0;
        check_eq("rand_start", 32'(random_o), 32'd7);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("rand_seq", 32'(random_o), 32'(exp_seq[k]));
        end
        wired_we_i = 1'b1;
        tick();
        wired_we_i = 1'b0;
        check_eq("rand_wired_force", 32'(random_o), 32'd7);

        // wired at top: Random parks at 7, TLBWR lands at index 7
        wired_we_i = 1'b1; wired_i = 3'd7;
        tick();
        wired_we_i = 1'b0;
        tick();
        check_eq("rand_hold", 32'(random_o), 32'd7);
        mask_i = '0; entryhi_i = 32'h0100_0001; tlbwr_i = 1'b1;
        tick();
        tlbwr_i = 1'b0; index_i = 3'd7;
        #1;
        check_eq("tlbwr_hi", entryhi_o, 32'h0100_0001);

        // TLBWI beats TLBWR
        index_i = 3'd1; entryhi_i = 32'h0200_0001; tlbwi_i = 1'b1; tlbwr_i = 1'b1;
        tick();
        tlbwi_i = 1'b0; tlbwr_i = 1'b0;
        check_eq("wi_wins_idx1", entryhi_o, 32'h0200_0001);
        index_i = 3'd7;
        #1;
        check_eq("wi_wins_idx7", entryhi_o, 32'h0100_0001);

        // async reset mid-operation
        kernel_mode_i = 1'b1; entryhi_i = 32'h0040_0001;
        lk_bus.lk_req_i = 2'b11; lk_bus.lk_va_i[0] = 32'hA000_1000; lk_bus.lk_va_i[1] = 32'hA000_2000;
        tlbp_i = 1'b1;
        tick();
        check_eq("pre_rst_vld", 32'(lk_bus.lk_vld_o), 32'd3);
        #2 rst = 1'b1;
        index_i = 3'd5;
        #1;
        check_eq("mid_rst_vld",    32'(lk_bus.lk_vld_o), 32'd0);
        check_eq("mid_rst_pa",     lk_bus.lk_pa_o[0], 32'h0);
        check_eq("mid_rst_probe",  32'(probe_done_o), 32'd0);
        check_eq("mid_rst_random", 32'(random_o), 32'd7);
        check_eq("mid_rst_lo0",    entrylo0_o, 32'h0000_0018);
        tlbp_i = 1'b0; lk_bus.lk_req_i = '0;
        tick();
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
